// File: rtl/mux_scan_pkg.sv
// Shared mode encodings and controller state type for the scanning N-to-1 mux.
package mux_scan_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    SCAN   = 2'b10,
    HOLD   = 2'b11
  } state_e;

  // The reserved encoding 2'b11 behaves exactly like HOLD.
  function automatic state_e modeToState(input logic [1:0] mode);
    case (mode)
      MODE_MANUAL: modeToState = MANUAL;
      MODE_SCAN:   modeToState = SCAN;
      default:     modeToState = HOLD;
    endcase
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Controller for the scanning mux: state register, scan pointer, dwell counter
// and wrap pulse; tells the datapath which channel to load and whether it exists.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DWELL    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel_in,
  output logic             load,
  output logic [SEL_W-1:0] idx,
  output logic             idx_legal,
  output logic             wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0] cnt_eff;
  logic             wrap_pend_q, wrap_pend_d;
  logic             wrap_q, wrap_d;

  // The pointer can only reach 0 again by advancing past the last channel,
  // so a pending flag set at that advance marks the next scan sample as a wrap.
  always_comb begin
    state_d     = state_q;
    scan_ptr_d  = scan_ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    wrap_pend_d = wrap_pend_q;
    wrap_d      = 1'b0;
    load        = 1'b0;
    idx         = scan_ptr_q;
    cnt_eff     = dwell_cnt_q;
    if (enable) begin
      state_d = modeToState(mode);
      case (state_d)
        MANUAL: begin
          load = 1'b1;
          idx  = sel_in;
        end
        SCAN: begin
          load        = 1'b1;
          wrap_d      = wrap_pend_q;
          wrap_pend_d = 1'b0;
          // Entering the scan restarts the dwell with this cycle as its first.
          cnt_eff     = (state_q == SCAN) ? dwell_cnt_q : '0;
          if (cnt_eff == LAST_CNT) begin
            dwell_cnt_d = '0;
            if (scan_ptr_q == LAST_CH) begin
              scan_ptr_d  = '0;
              wrap_pend_d = 1'b1;
            end else begin
              scan_ptr_d = scan_ptr_q + 1'b1;
            end
          end else begin
            dwell_cnt_d = cnt_eff + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_legal = (32'(idx) < 32'(CHANNELS));
  assign wrap      = wrap_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_ptr_q  <= '0;
      dwell_cnt_q <= '0;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_d;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 multiplexer with manual select, timed auto-scan and hold;
// the controller picks the channel, this level muxes and registers the sample.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          q,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      valid,
  output logic                      wrap
);

  logic             load;
  logic [SEL_W-1:0] idx;
  logic             idx_legal;
  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] q_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;

  mux_scan_ctrl #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .sel_in    (sel_in),
    .load      (load),
    .idx       (idx),
    .idx_legal (idx_legal),
    .wrap      (wrap)
  );

  // Compare-based mux so an index past the last channel never addresses data_in.
  always_comb begin
    mux_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SEL_W'(i)) begin
        mux_d = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      q_q     <= idx_legal ? mux_d : '0;
      ch_q    <= idx;
      valid_q <= idx_legal;
    end
  end

  assign q      = q_q;
  assign ch_out = ch_q;
  assign valid  = valid_q;

endmodule
